// File: rtl/wdt_bus_pkg.sv
// Shared types and constants for the watchdog register-bus initiator.
// Holds the FSM state encoding, the response record and the register map.
package wdt_bus_pkg;

    localparam int BUS_DATA_W = 8;

    localparam logic [7:0] WDT_LOAD_ADDR = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_t;

    typedef struct packed {
        logic [BUS_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

    // A zero TIMEOUT still needs a one-bit counter so the port list stays legal.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/wdt_bus_wait_timer.sv
// Clearable up-counter that flags the last permitted wait cycle of an access.
// With TIMEOUT = 0 the flag never rises, so accesses may wait forever.
module wdt_bus_wait_timer
    import wdt_bus_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] r_count;
    logic             w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && !w_expire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_expire = (r_count == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    assign o_expire = w_expire;

endmodule

// File: rtl/wdt_bus_master.sv
// Single-outstanding register-bus initiator with a bounded wait for pready.
// Bus outputs are registered; the response pulses during the TURN cycle.
module wdt_bus_master
    import wdt_bus_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk_i,
    input  logic              prst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [DATA_W-1:0] pwdata_o,
    output logic              pwrite_o,
    output logic              penable_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_pwrite;
    logic              r_penable;
    rsp_t              r_rsp;

    logic w_expire;
    logic w_handshake;
    logic w_done;
    logic w_req_ready;
    logic w_busy;
    logic w_rsp_valid;

    assign w_handshake = (r_state == IDLE) && req_valid_i;
    assign w_done      = (r_state == ACCESS) && (pready_i || w_expire);

    wdt_bus_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (pclk_i),
        .rst_n    (prst_n_i),
        .i_clear  (r_state != ACCESS),
        .i_run    (r_state == ACCESS),
        .o_expire (w_expire)
    );

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid_i) w_next_state = ACCESS;
            ACCESS:  if (pready_i || w_expire) w_next_state = TURN;
            TURN:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = 1'b0;
        w_busy      = 1'b1;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                w_busy      = 1'b0;
            end
            TURN:    w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture the request onto the bus and, on completion, the response record.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_penable <= 1'b0;
            r_rsp     <= '0;
        end else if (w_handshake) begin
            r_paddr   <= req_addr_i;
            r_pwdata  <= req_write_i ? req_wdata_i : '0;
            r_pwrite  <= req_write_i;
            r_penable <= 1'b1;
        end else if (w_done) begin
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_penable <= 1'b0;
            if (pready_i) begin
                r_rsp.rdata   <= r_pwrite ? '0 : BUS_DATA_W'(prdata_i);
                r_rsp.err     <= pslverr_i;
                r_rsp.timeout <= 1'b0;
            end else begin
                r_rsp.rdata   <= '0;
                r_rsp.err     <= 1'b1;
                r_rsp.timeout <= 1'b1;
            end
        end
    end

    // Ready is masked by reset so nothing reads as acceptable while held in reset.
    assign req_ready_o   = w_req_ready && prst_n_i;
    assign busy_o        = w_busy;
    assign rsp_valid_o   = w_rsp_valid;
    assign rsp_rdata_o   = DATA_W'(r_rsp.rdata);
    assign rsp_err_o     = r_rsp.err;
    assign rsp_timeout_o = r_rsp.timeout;
    assign paddr_o       = r_paddr;
    assign pwdata_o      = r_pwdata;
    assign pwrite_o      = r_pwrite;
    assign penable_o     = r_penable;

endmodule

// File: tb/tb_wdt_bus_master.sv
// Directed bench for wdt_bus_master: writes, reads, slave errors, timeouts,
// back-to-back requests and reset during an access.
module tb_wdt_bus_master;

    logic       pclk_i;
    logic       prst_n_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic       req_write_i;
    logic [7:0] req_addr_i;
    logic [7:0] req_wdata_i;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic       rsp_err_o;
    logic       rsp_timeout_o;
    logic       busy_o;
    logic [7:0] paddr_o;
    logic [7:0] pwdata_o;
    logic       pwrite_o;
    logic       penable_o;
    logic [7:0] prdata_i;
    logic       pready_i;
    logic       pslverr_i;

    int checks = 0;
    int errors = 0;

    wdt_bus_master #(
        .ADDR_W  (8),
        .DATA_W  (8),
        .TIMEOUT (16)
    ) dut (
        .pclk_i        (pclk_i),
        .prst_n_i      (prst_n_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pwrite_o      (pwrite_o),
        .penable_o     (penable_o),
        .prdata_i      (prdata_i),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i)
    );

    initial pclk_i = 1'b0;
    always #5 pclk_i = ~pclk_i;

    // Issues one request from IDLE; the slave answers after `waits` cycles of
    // penable (negative: never). Returns the bus snapshot and the response.
    task automatic do_transfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input int waits, input logic [7:0] rdat, input logic serr,
                               output int en_cyc, output logic [7:0] s_addr,
                               output logic [7:0] s_wdata, output logic s_write,
                               output logic got_rsp, output logic [7:0] r_rdata,
                               output logic r_err, output logic r_to);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        @(posedge pclk_i); #1;
        req_valid_i = 1'b0;
        req_addr_i  = 8'hFF;
        req_wdata_i = 8'hFF;
        s_addr  = paddr_o;
        s_wdata = pwdata_o;
        s_write = pwrite_o;
        en_cyc  = 0;
        while (penable_o === 1'b1 && en_cyc < 100) begin
            en_cyc++;
            if (waits >= 0 && en_cyc - 1 == waits) begin
                pready_i  = 1'b1;
                prdata_i  = rdat;
                pslverr_i = serr;
            end
            @(posedge pclk_i); #1;
            pready_i  = 1'b0;
            pslverr_i = 1'b0;
            prdata_i  = 8'hEE;
        end
        got_rsp = rsp_valid_o;
        r_rdata = rsp_rdata_o;
        r_err   = rsp_err_o;
        r_to    = rsp_timeout_o;
    endtask

    task automatic test_reset();
        prst_n_i = 1'b0;
        #3;
        checks++;
        if ({req_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, penable_o, pwrite_o} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                     {req_ready_o, busy_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, penable_o, pwrite_o});
        end
        checks++;
        if ({paddr_o, pwdata_o, rsp_rdata_o} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 000000", {paddr_o, pwdata_o, rsp_rdata_o});
        end
        @(negedge pclk_i);
        prst_n_i = 1'b1;
        @(posedge pclk_i); #1;
        checks++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: ready=%b busy=%b expected ready=1 busy=0", req_ready_o, busy_o);
        end
    endtask

    task automatic test_write();
        int en; logic [7:0] a, w, rd; logic wr, got, er, to;
        do_transfer(1'b1, 8'h00, 8'hC8, 1, 8'hEE, 1'b0, en, a, w, wr, got, rd, er, to);
        checks++;
        if (a !== 8'h00 || w !== 8'hC8 || wr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_bus: paddr=%h pwdata=%h pwrite=%b expected 00 c8 1", a, w, wr);
        end
        checks++;
        if (en !== 2) begin
            errors++;
            $display("[TB] FAIL write_penable_len: got %0d expected 2", en);
        end
        checks++;
        if ({got, er, to, rd} !== {3'b100, 8'h00}) begin
            errors++;
            $display("[TB] FAIL write_rsp: valid=%b err=%b to=%b rdata=%h expected 1 0 0 00", got, er, to, rd);
        end
        @(posedge pclk_i); #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_pulse_end: valid=%b ready=%b expected 0 1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_read();
        int en; logic [7:0] a, w, rd; logic wr, got, er, to;
        do_transfer(1'b0, 8'h04, 8'h77, 0, 8'h5A, 1'b0, en, a, w, wr, got, rd, er, to);
        checks++;
        if (a !== 8'h04 || w !== 8'h00 || wr !== 1'b0 || en !== 1) begin
            errors++;
            $display("[TB] FAIL read_bus: paddr=%h pwdata=%h pwrite=%b en=%0d expected 04 00 0 1", a, w, wr, en);
        end
        checks++;
        if ({got, er, to, rd} !== {3'b100, 8'h5A}) begin
            errors++;
            $display("[TB] FAIL read_rsp: valid=%b err=%b to=%b rdata=%h expected 1 0 0 5a", got, er, to, rd);
        end
        @(posedge pclk_i); #1;
        checks++;
        if (rsp_rdata_o !== 8'h5A || rsp_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_hold: rdata=%h valid=%b expected 5a 0", rsp_rdata_o, rsp_valid_o);
        end
    endtask

    task automatic test_slave_error();
        int en; logic [7:0] a, w, rd; logic wr, got, er, to;
        do_transfer(1'b1, 8'h08, 8'h33, 0, 8'hEE, 1'b1, en, a, w, wr, got, rd, er, to);
        checks++;
        if ({got, er, to, rd} !== {3'b110, 8'h00}) begin
            errors++;
            $display("[TB] FAIL slverr_rsp: valid=%b err=%b to=%b rdata=%h expected 1 1 0 00", got, er, to, rd);
        end
        @(posedge pclk_i); #1;
        do_transfer(1'b0, 8'h0C, 8'h00, 2, 8'hA5, 1'b0, en, a, w, wr, got, rd, er, to);
        checks++;
        if (en !== 3 || {got, er, to, rd} !== {3'b100, 8'hA5}) begin
            errors++;
            $display("[TB] FAIL slverr_next: en=%0d valid=%b err=%b to=%b rdata=%h expected 3 1 0 0 a5",
                     en, got, er, to, rd);
        end
        @(posedge pclk_i); #1;
    endtask

    task automatic test_timeout();
        int en; logic [7:0] a, w, rd; logic wr, got, er, to;
        do_transfer(1'b0, 8'h10, 8'h00, -1, 8'hEE, 1'b0, en, a, w, wr, got, rd, er, to);
        checks++;
        if (en !== 16) begin
            errors++;
            $display("[TB] FAIL timeout_len: got %0d expected 16", en);
        end
        checks++;
        if ({got, er, to, rd} !== {3'b111, 8'h00}) begin
            errors++;
            $display("[TB] FAIL timeout_rsp: valid=%b err=%b to=%b rdata=%h expected 1 1 1 00", got, er, to, rd);
        end
        @(posedge pclk_i); #1;
        do_transfer(1'b0, 8'h10, 8'h00, 15, 8'h3C, 1'b0, en, a, w, wr, got, rd, er, to);
        checks++;
        if (en !== 16 || {got, er, to, rd} !== {3'b100, 8'h3C}) begin
            errors++;
            $display("[TB] FAIL timeout_race: en=%0d valid=%b err=%b to=%b rdata=%h expected 16 1 0 0 3c",
                     en, got, er, to, rd);
        end
        @(posedge pclk_i); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs[3];
        logic [7:0] wdats[3];
        int gaps[3];
        int k = 0, ntr = 0, nrsp = 0, gap = 0;
        logic prev_en = 1'b0;
        logic ready_now;
        pready_i    = 1'b1;
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 8'h01;
        req_wdata_i = 8'h11;
        for (int cyc = 0; cyc < 20; cyc++) begin
            ready_now = req_ready_o;
            @(posedge pclk_i); #1;
            if (ready_now && req_valid_i) begin
                k++;
                if (k < 3) begin
                    req_addr_i  = 8'(k + 1);
                    req_wdata_i = 8'(8'h11 * (k + 1));
                end else begin
                    req_valid_i = 1'b0;
                end
            end
            if (penable_o === 1'b1) begin
                if (!prev_en && ntr < 3) begin
                    addrs[ntr] = paddr_o;
                    wdats[ntr] = pwdata_o;
                    gaps[ntr]  = gap;
                    ntr++;
                end
                gap = 0;
            end else begin
                gap++;
            end
            if (rsp_valid_o === 1'b1) nrsp++;
            prev_en = penable_o;
        end
        pready_i = 1'b0;
        checks++;
        if (ntr !== 3 || nrsp !== 3) begin
            errors++;
            $display("[TB] FAIL b2b_count: transfers=%0d responses=%0d expected 3 3", ntr, nrsp);
        end
        for (int i = 0; i < ntr; i++) begin
            checks++;
            if (addrs[i] !== 8'(i + 1) || wdats[i] !== 8'(8'h11 * (i + 1))) begin
                errors++;
                $display("[TB] FAIL b2b_order[%0d]: paddr=%h pwdata=%h expected %h %h",
                         i, addrs[i], wdats[i], 8'(i + 1), 8'(8'h11 * (i + 1)));
            end
            if (i > 0) begin
                checks++;
                if (gaps[i] !== 2) begin
                    errors++;
                    $display("[TB] FAIL b2b_gap[%0d]: got %0d expected 2", i, gaps[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int en, nrsp = 0; logic [7:0] a, w, rd; logic wr, got, er, to;
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 8'h20;
        req_wdata_i = 8'h99;
        @(posedge pclk_i); #1;
        req_valid_i = 1'b0;
        repeat (3) @(posedge pclk_i);
        #2;
        checks++;
        if (penable_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_pre: penable=%b expected 1", penable_o);
        end
        prst_n_i = 1'b0;
        #1;
        checks++;
        if ({req_ready_o, busy_o, rsp_valid_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== 21'h0) begin
            errors++;
            $display("[TB] FAIL midrst_async: got %h expected 0",
                     {req_ready_o, busy_o, rsp_valid_o, penable_o, pwrite_o, paddr_o, pwdata_o});
        end
        repeat (2) begin
            @(posedge pclk_i); #1;
            if (rsp_valid_o === 1'b1) nrsp++;
        end
        @(negedge pclk_i);
        prst_n_i = 1'b1;
        repeat (2) begin
            @(posedge pclk_i); #1;
            if (rsp_valid_o === 1'b1) nrsp++;
        end
        checks++;
        if (nrsp !== 0 || req_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_after: responses=%0d ready=%b expected 0 1", nrsp, req_ready_o);
        end
        do_transfer(1'b0, 8'h04, 8'h00, 1, 8'hC3, 1'b0, en, a, w, wr, got, rd, er, to);
        checks++;
        if (en !== 2 || a !== 8'h04 || {got, er, to, rd} !== {3'b100, 8'hC3}) begin
            errors++;
            $display("[TB] FAIL midrst_read: en=%0d paddr=%h valid=%b err=%b to=%b rdata=%h expected 2 04 1 0 0 c3",
                     en, a, got, er, to, rd);
        end
    endtask

    initial begin
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = 8'h00;
        req_wdata_i = 8'h00;
        prdata_i    = 8'hEE;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        @(posedge pclk_i); #1;
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/wdt_bus_master.md
Name: wdt_bus_master

Overview:
Bus initiator for the processor register interface used by the watchdog timer and sibling peripherals. It accepts one register request at a time on a valid/ready command port and drives paddr/pwdata/pwrite/penable. It waits for pready, then returns read data and error status on a one-cycle response pulse. A bounded wait timer aborts transfers to a slave that never responds, so a hung peripheral cannot stall the host sequencer.

Parameters:
ADDR_W, 8, width of paddr_o / req_addr_i
DATA_W, 8, width of pwdata_o / prdata_i / request and response data
TIMEOUT, 16, maximum cycles penable_o stays high waiting for pready_i; 0 disables the timeout

Ports:
pclk_i  in  1  clock; all logic on rising edge
prst_n_i  in  1  asynchronous active-low reset
req_valid_i  in  1  request present
req_ready_o  out  1  master can accept a request this cycle
req_write_i  in  1  1 = write, 0 = read
req_addr_i  in  ADDR_W  register address
req_wdata_i  in  DATA_W  write data, ignored on reads
rsp_valid_o  out  1  one-cycle pulse: transfer finished
rsp_rdata_o  out  DATA_W  read data; 0 for writes and timeouts
rsp_err_o  out  1  slave error or timeout
rsp_timeout_o  out  1  transfer aborted by the timeout
busy_o  out  1  state != IDLE
paddr_o  out  ADDR_W  bus address
pwdata_o  out  DATA_W  bus write data
pwrite_o  out  1  bus direction
penable_o  out  1  bus access active
prdata_i  in  DATA_W  slave read data
pready_i  in  1  slave completes the access
pslverr_i  in  1  slave error; valid only with pready_i

Behaviour:
- Reset (prst_n_i=0, asynchronous): state IDLE, wait counter 0. All outputs 0, including req_ready_o, busy_o and all bus outputs.
- Reset asserted mid-transfer: penable_o drops immediately and no response is issued.
- Bus outputs are registered. The FSM has three states: IDLE, ACCESS, TURN.
- IDLE:
  - req_ready_o=1; bus outputs 0.
  - A handshake is req_valid_i & req_ready_o at an edge. On that edge: latch the request, drive paddr_o/pwrite_o, drive pwdata_o (0 on reads), set penable_o=1, clear the counter, go to ACCESS.
- ACCESS:
  - req_ready_o=0; bus outputs held stable.
  - Edge with pready_i=1: completion. rsp_rdata_o takes prdata_i on a read and 0 on a write. rsp_err_o takes pslverr_i. rsp_valid_o=1 for the next cycle. All bus outputs go to 0. Go to TURN.
  - Edge with pready_i=0 and counter==TIMEOUT-1 (TIMEOUT>0): abort. rsp_valid_o=1, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0. Bus outputs go to 0. Go to TURN.
  - Otherwise the counter increments. Counter width is $clog2(TIMEOUT+1).
  - With TIMEOUT>0, penable_o is high for at most TIMEOUT cycles.
- TURN:
  - One cycle; bus outputs 0; rsp_valid_o high during this cycle only.
  - rsp_* data fields hold until the next response.
  - Next state is IDLE.
- Latency:
  - With a zero-wait slave (pready_i high already), penable_o is high for 1 cycle.
  - rsp_valid_o is high in the cycle after the completion edge.
  - Between back-to-back transfers, penable_o is low for exactly 2 cycles (TURN, then IDLE).
- Pready and timeout on the same edge: pready wins, a normal completion with rsp_timeout_o=0.
- pready_i and pslverr_i are ignored outside ACCESS.
- req_* inputs are ignored unless a handshake occurs.

Decomposition:
- Package wdt_bus_pkg holds:
  - the state enum (IDLE, ACCESS, TURN);
  - the response struct (rdata, err, timeout);
  - watchdog register address constants (WDT_LOAD_ADDR = 8'h00).
- Sub-module wdt_bus_wait_timer: clearable up-counter with an expire flag. TIMEOUT is a parameter; TIMEOUT=0 means it never expires. The FSM stays in the top module.

Test Plan:
- Write addr 0x00, data 0xC8 (200); slave raises pready 1 cycle after penable -> paddr_o=0x00, pwdata_o=0xC8, pwrite_o=1, penable_o high 2 cycles; rsp_valid_o one pulse with err=0, timeout=0, rdata=0.
- Read addr 0x04; slave returns prdata_i=0x5A with zero wait -> penable_o high 1 cycle, pwdata_o=0, rsp_rdata_o=0x5A, rsp_err_o=0.
- Write with pready_i=1 and pslverr_i=1 -> rsp_err_o=1, rsp_timeout_o=0; next request still accepted.
- TIMEOUT=16, slave never asserts pready -> penable_o high exactly 16 cycles, then rsp_valid_o with err=1, timeout=1, rdata=0. Repeat with pready_i=1 on the 16th edge -> normal completion, timeout=0.
- req_valid_i held high for 3 back-to-back writes (0x01, 0x02, 0x03) -> 3 ordered bus transfers, penable_o low exactly 2 cycles between them, 3 rsp_valid_o pulses.
- prst_n_i pulsed low mid-ACCESS -> all outputs 0 asynchronously, no rsp_valid_o; after release, req_ready_o=1 and a read completes normally.
